// File: rtl/matrix_stream_pkg.sv
// Shared types and helpers for the matrix result streaming path.
// Holds the stream FSM encoding and tag-width helper.
package matrix_stream_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } stream_state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/row_col_counter.sv
// Row-major 2-D index counter; load zeroes it, advance steps col then row.
// Wrap flags flag the last column / last row of the current index.
module row_col_counter
  import matrix_stream_pkg::*;
#(
  parameter  int M     = 8,
  parameter  int P     = 8,
  localparam int ROW_W = clog2_min1(M),
  localparam int COL_W = clog2_min1(P)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             col_wrap,
  output logic             row_wrap
);

  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(M - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(P - 1);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;

  assign col_wrap = (col_q == COL_MAX);
  assign row_wrap = (row_q == ROW_MAX);
  assign row      = row_q;
  assign col      = col_q;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (load) begin
      row_d = '0;
      col_d = '0;
    end else if (advance) begin
      if (col_wrap) begin
        col_d = '0;
        row_d = row_wrap ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/matrix_result_streamer.sv
// Captures a packed M x P result on done_in and streams it row-major
// over valid/ready with row/col tags and last flags.
module matrix_result_streamer
  import matrix_stream_pkg::*;
#(
  parameter  int RESULT_WIDTH = 16,
  parameter  int M            = 8,
  parameter  int P            = 8,
  localparam int ROW_W        = clog2_min1(M),
  localparam int COL_W        = clog2_min1(P)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        done_in,
  input  logic [M*P*RESULT_WIDTH-1:0] result_c,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [RESULT_WIDTH-1:0]     out_data,
  output logic [ROW_W-1:0]            out_row,
  output logic [COL_W-1:0]            out_col,
  output logic                        out_last_row,
  output logic                        out_last,
  output logic                        busy,
  output logic                        overrun,
  input  logic                        clr_overrun
);

  stream_state_t state_q, state_d;
  logic [M*P*RESULT_WIDTH-1:0] buf_q, buf_d;
  logic overrun_q, overrun_d;

  logic col_wrap, row_wrap;
  logic hs, fin, accept, drop;

  logic [RESULT_WIDTH-1:0] elem [M][P];

  for (genvar i = 0; i < M; i++) begin : g_row
    for (genvar j = 0; j < P; j++) begin : g_col
      assign elem[i][j] =
        buf_q[(i*P+j)*RESULT_WIDTH +: RESULT_WIDTH];
    end
  end

  assign out_valid    = (state_q == STREAM);
  assign busy         = out_valid;
  assign out_last_row = out_valid & col_wrap;
  assign out_last     = out_valid & col_wrap & row_wrap;
  assign out_data     = out_valid ? elem[out_row][out_col] : '0;
  assign overrun      = overrun_q;

  assign hs     = out_valid & out_ready;
  assign fin    = hs & out_last;
  // A new frame may only land when idle or on the closing beat.
  assign accept = done_in & (!out_valid | fin);
  assign drop   = done_in & out_valid & !fin;

  row_col_counter #(
    .M (M),
    .P (P)
  ) u_idx (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .advance  (hs),
    .row      (out_row),
    .col      (out_col),
    .col_wrap (col_wrap),
    .row_wrap (row_wrap)
  );

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    overrun_d = overrun_q;
    if (accept) begin
      state_d = STREAM;
      buf_d   = result_c;
    end else if (fin) begin
      state_d = IDLE;
    end
    if (drop) overrun_d = 1'b1;
    else if (clr_overrun) overrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      buf_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Scoreboard bench for matrix_result_streamer on a 2x2 frame.
// Driver pushes expected beats; a negedge monitor pops and compares.
module tb_matrix_result_streamer;

  localparam int W = 16;
  localparam int M = 2;
  localparam int P = 2;

  typedef struct packed {
    logic [W-1:0] d;
    logic         r;
    logic         c;
    logic         lr;
    logic         l;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             done_in;
  logic [M*P*W-1:0] result_c;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic             out_row;
  logic             out_col;
  logic             out_last_row;
  logic             out_last;
  logic             busy;
  logic             overrun;
  logic             clr_overrun;

  int checks = 0;
  int errors = 0;

  beat_t exp_q[$];
  beat_t held;
  logic  hold_pend = 1'b0;

  always #5 clk = ~clk;

  matrix_result_streamer #(
    .RESULT_WIDTH (W),
    .M            (M),
    .P            (P)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .done_in      (done_in),
    .result_c     (result_c),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_row      (out_row),
    .out_col      (out_col),
    .out_last_row (out_last_row),
    .out_last     (out_last),
    .busy         (busy),
    .overrun      (overrun),
    .clr_overrun  (clr_overrun)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic beat_t cur_beat();
    return {out_data, out_row, out_col, out_last_row, out_last};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [W-1:0] e0, e1, e2, e3);
    result_c = {e3, e2, e1, e0};
    exp_q.push_back({e0, 1'b0, 1'b0, 1'b0, 1'b0});
    exp_q.push_back({e1, 1'b0, 1'b1, 1'b1, 1'b0});
    exp_q.push_back({e2, 1'b1, 1'b0, 1'b0, 1'b0});
    exp_q.push_back({e3, 1'b1, 1'b1, 1'b1, 1'b1});
  endtask

  task automatic pulse_done();
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst && out_valid) begin
      if (hold_pend)
        check("hold_stable", 32'(cur_beat()), 32'(held));
      if (out_ready) begin
        hold_pend = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(cur_beat()), 32'hDEAD);
        end else begin
          check("beat", 32'(cur_beat()), 32'(exp_q.pop_front()));
        end
      end else begin
        hold_pend = 1'b1;
        held      = cur_beat();
      end
    end else begin
      hold_pend = 1'b0;
    end
  end

  initial begin
    logic rdy_pat [7];
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    rst         = 1'b0;
    done_in     = 1'b0;
    out_ready   = 1'b0;
    clr_overrun = 1'b0;
    result_c    = '0;
    tick();
    tick();
    check("reset_outs",
          {out_valid, busy, overrun, out_data, out_row, out_col,
           out_last_row, out_last}, 32'h0);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_outs",
            {out_valid, busy, overrun, out_data, out_row, out_col,
             out_last_row, out_last}, 32'h0);
    end

    // basic frame, ready held high
    out_ready = 1'b1;
    push_frame(16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000);
    pulse_done();
    check("first_valid", {out_valid, busy}, 32'h3);
    repeat (4) tick();
    check("basic_end", {out_valid, busy}, 32'h0);
    check("basic_drain", exp_q.size(), 0);

    // backpressure pattern
    push_frame(16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000);
    pulse_done();
    for (int i = 0; i < 7; i++) begin
      out_ready = rdy_pat[i];
      tick();
    end
    check("bp_end", {out_valid, busy}, 32'h0);
    check("bp_drain", exp_q.size(), 0);

    // back-to-back frames with done on final handshake
    out_ready = 1'b1;
    push_frame(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    pulse_done();
    repeat (3) tick();
    check("b2b_last_pending", out_last, 32'h1);
    push_frame(16'h0010, 16'h0011, 16'h0012, 16'h0013);
    pulse_done();
    check("b2b_valid", {out_valid, out_data, out_row, out_col}, 32'h10010 << 2);
    check("b2b_overrun", overrun, 32'h0);
    repeat (4) tick();
    check("b2b_end", out_valid, 32'h0);
    check("b2b_drain", exp_q.size(), 0);

    // overrun: done during beat 2
    push_frame(16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3);
    pulse_done();
    tick();
    result_c = {4{16'hBEEF}};
    pulse_done();
    check("ovr_set", overrun, 32'h1);
    repeat (2) tick();
    check("ovr_end", out_valid, 32'h0);
    check("ovr_drain", exp_q.size(), 0);
    repeat (3) tick();
    check("ovr_held", overrun, 32'h1);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    check("ovr_clr", overrun, 32'h0);

    // async reset mid-frame under backpressure
    out_ready = 1'b0;
    push_frame(16'h0C00, 16'h0C01, 16'h0C02, 16'h0C03);
    pulse_done();
    repeat (2) tick();
    check("pre_rst_valid", out_valid, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst",
          {out_valid, busy, out_data, out_row, out_col}, 32'h0);
    exp_q.delete();
    tick();
    rst       = 1'b1;
    out_ready = 1'b1;
    repeat (5) begin
      tick();
      check("post_rst_idle", {out_valid, busy}, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_result_streamer.md
Name: matrix_result_streamer

Overview:
Downstream stage of systolic_matrix_multiplier. Captures the packed result_c word on the multiplier's done pulse and streams the M*P elements row-major over a valid/ready interface. Row and column tags and last flags are attached to each element. The block frees the multiplier for the next job as soon as capture completes; it does not wait for draining to finish.

Parameters:
RESULT_WIDTH, 16, width of one result element (matches multiplier RESULT_WIDTH)
M, 8, result rows
P, 8, result columns
ROW_W, $clog2(M) (min 1), width of row tag (derived, localparam)
COL_W, $clog2(P) (min 1), width of column tag (derived, localparam)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
done_in  input  1  one-cycle done pulse from systolic_matrix_multiplier
result_c  input  M*P*RESULT_WIDTH  packed result; element (i,j) at bits [(i*P+j)*RESULT_WIDTH +: RESULT_WIDTH]
out_valid  output  1  element available
out_ready  input  1  consumer accepts element
out_data  output  RESULT_WIDTH  current element, raw bits (signed two's complement, no modification)
out_row  output  ROW_W  row index i of out_data
out_col  output  COL_W  column index j of out_data
out_last_row  output  1  high when out_col == P-1
out_last  output  1  high when out_row == M-1 and out_col == P-1
busy  output  1  frame held or streaming
overrun  output  1  sticky: a done_in pulse was dropped
clr_overrun  input  1  synchronous clear of overrun

Behaviour:
- Reset (rst low, async): state IDLE; out_valid=0, out_data=0, out_row=0, out_col=0, out_last_row=0, out_last=0, busy=0, overrun=0; capture buffer cleared. Reset mid-frame abandons the frame; no element is emitted after reset is released until a new done_in arrives.
- States: IDLE, STREAM.
- IDLE: done_in=1 at edge -> result_c copied to internal buffer, row=col=0, go to STREAM. out_valid=1 and busy=1 are registered and visible the cycle after the done_in edge, so latency is 1 cycle from done to the first element.
- STREAM: out_valid=1. A handshake is out_valid & out_ready at the clock edge.
- On handshake, col advances; at col==P-1, col wraps to 0 and row increments.
- If out_ready=0, out_data, tags and flags are held stable. out_valid never drops without a handshake.
- Final handshake (out_last=1): return to IDLE, out_valid=0, busy=0. A done_in in the same cycle is accepted instead: buffer reloaded, row=col=0, stay in STREAM, out_valid stays 1 (back-to-back frames, no bubble).
- done_in in STREAM other than on the final handshake: pulse ignored, buffer untouched, overrun set to 1.
- overrun stays set until clr_overrun=1. If clr_overrun and a new drop event occur in the same cycle, set wins.
- out_data is a combinational mux of the buffer by the registered (row,col). Equivalently it may be registered, provided the same cycle timing is kept.
- Throughput: 1 element/cycle with out_ready held high. A full frame takes M*P cycles after the first out_valid.
- M=1 or P=1 is legal. out_last_row is then constant 1 while valid (P=1), and out_last follows the column rule (M=1).

Decomposition:
- Shared package matrix_stream_pkg: state enum (IDLE, STREAM), function clog2_min1 for tag widths.
- No sub-module required. An optional 2-D index counter row_col_counter (inputs: advance, load; outputs: row, col, wrap flags) is natural and reusable by an upstream A/B loader.

Test Plan:
- Reset/idle (8x8): rst low, then high, no done_in -> out_valid=0 and busy=0 for 20 cycles, all outputs 0.
- Basic frame (M=P=2, RESULT_WIDTH=16): result_c elements {C00=0x0001, C01=0xFFFF, C10=0x7FFF, C11=0x8000}, done_in pulse, out_ready=1 -> out_valid from the next cycle. Sequence 0x0001, 0xFFFF, 0x7FFF, 0x8000 with (row,col)=(0,0),(0,1),(1,0),(1,1); out_last_row on beats 2 and 4; out_last on beat 4 only. out_valid=0 and busy=0 the cycle after.
- Backpressure: same frame with out_ready toggling 1,0,0,1,0,1,1 -> each element is held stable while out_ready=0, no loss or duplication, 4 handshakes total.
- Back-to-back: second done_in (new data 0x0010..0x0013) coincides with the final handshake -> out_valid stays high, next beat is 0x0010 at (0,0), overrun=0.
- Overrun: done_in during beat 2 of a frame -> frame finishes unchanged, overrun=1 and held. clr_overrun pulse -> overrun=0.
- Full 8x8 with the multiplier in the loop: random signed 8-bit A/B from init files, out_ready random 70% -> 64 streamed values match the reference model in row-major order; out_last on element 63. An async reset asserted mid-frame (element 20) drops out_valid immediately.
